conv_2d_3x3: RTL and testbench
==============================

Name: conv_2d_3x3

Overview:
- Streaming 3x3 2-D convolution (correlation) engine for the image-processing datapath.
- Loads a 3x3 signed kernel one column per clock.
- Receives a padded image one 3-pixel column per clock (three vertically adjacent rows) and emits one filtered signed pixel per clock once its 3-column window is full.
- The upstream frame reader does the row/column scanning; this block does only the windowing and the MAC.

Parameters:
- DATA_W, 8, pixel and kernel word width (signed, two's complement).
- FRAC_W, 7, fractional bits of pixels, kernel and output (Q1.7).
- ACC_W, 20, accumulator width (2*DATA_W+4, holds 9 full-scale products).

Ports:
- clk  in  1  rising-edge clock.
- i_rst  in  1  synchronous reset, active-high.
- i_load_knl  in  1  kernel-column load strobe.
- i_en_conv  in  1  pixel-column shift/compute enable.
- i_data1  in  DATA_W  top row of the column (kernel row 0, or image row r).
- i_data2  in  DATA_W  middle row (kernel row 1, or image row r+1).
- i_data3  in  DATA_W  bottom row (kernel row 2, or image row r+2).
- o_pixel  out  DATA_W  signed Q1.7 result.
- o_valid  out  1  o_pixel holds a result from a full window.

Behaviour:
- Reset (i_rst=1 at an edge): kernel regs, window regs, column count, o_pixel and o_valid all go to 0. Reset has priority over every other input, including in mid-stream.
- Kernel load: each edge with i_load_knl=1 shifts the kernel columns left (k[.][0]<=k[.][1], k[.][1]<=k[.][2]) and writes k[0][2]<=i_data1, k[1][2]<=i_data2, k[2][2]<=i_data3.
  - After 3 load cycles, the first column loaded is column 0.
  - Row-major k1..k9 is therefore loaded as (k1,k4,k7), (k2,k5,k8), (k3,k6,k9).
- A load cycle also clears the column count and o_valid.
- i_load_knl and i_en_conv both high: load wins and the pixel path holds.
- Pixel shift: each edge with i_en_conv=1 and i_load_knl=0 shifts the window columns left identically and inserts i_data1..3 into column 2. The column count increments, saturating at 3.
- Compute: the combinational sum S = sum over r,c of k[r][c]*w[r][c] uses the window after the shift. It is signed, with each product sign-extended to ACC_W.
- o_pixel is registered on the edge after the window update, so latency is 1 clock from the window becoming full.
  - For the column presented at edge N that completes a window, o_pixel and o_valid=1 appear after edge N+1.
- Scaling: o_pixel = S arithmetically shifted right by FRAC_W (floor), then narrowed to DATA_W per the optional feature.
- i_en_conv=0 and i_load_knl=0: everything holds. o_valid drops to 0 after one edge; o_pixel keeps its last value.
- o_valid=1 exactly on cycles following a shift whose column count (post-shift) is 3.
- The block has no knowledge of row boundaries. Windows straddling the end of one row and the start of the next are computed and flagged valid. The consumer discards the first 2 outputs of each row after the first (W-2 good outputs per padded row of W).

Optional Feature:
- CONV2D_SAT_EN defined: values above 0x7F clamp to 0x7F (+0.9921875) and values below 0x80 clamp to 0x80 (-1.0).
- CONV2D_SAT_EN undefined: two's-complement wrap, keeping the low DATA_W bits after the shift.

Decomposition:
- Package conv_2d_pkg: DATA_W, FRAC_W, ACC_W defaults; the pixel_t and acc_t signed typedefs; saturation bounds MAX_Q, MIN_Q.
- Sub-module conv_mac3x3: purely combinational, 9 kernel words plus 9 window words in, ACC_W sum out. The top holds the registers, control, scaling and saturation.

Test Plan:
- Center-only kernel 0x80 (-1.0), others 0; rows of pixel 0x20 -> after 3 columns plus 1 clock, o_pixel=0xE0, o_valid=1, then one result per clock.
- Same kernel, center pixel 0x80 -> 0x7F with CONV2D_SAT_EN, 0x80 without.
- All nine kernel taps 0x10 (0.125), all pixels 0x40 -> sum 9216, o_pixel=0x48.
- Column-order check: kernel k1..k9 = 1..9 (raw), window with a single 0x7F at row 1 column 0 -> o_pixel equals floor(4*127/128)=0x03, proving (k1,k4,k7) is column 0.
- i_rst asserted for 1 cycle mid-stream -> o_pixel=0 and o_valid=0 on the next edge; 3 new columns are needed before o_valid=1 again, and the kernel must be reloaded (kernel is 0, so the output is 0).
- i_load_knl and i_en_conv high together -> window unchanged, kernel shifted, o_valid=0.

Source files
------------

// File: rtl/conv_2d_pkg.sv
// Shared widths, signed types and Q1.7 saturation bounds for the 3x3 convolution engine.
package conv_2d_pkg;

    localparam int DATA_W = 8;
    localparam int FRAC_W = 7;
    localparam int ACC_W  = 2 * DATA_W + 4;

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam pixel_t MAX_Q = pixel_t'((2 ** (DATA_W - 1)) - 1);
    localparam pixel_t MIN_Q = pixel_t'(-(2 ** (DATA_W - 1)));

    // Reinterpret a raw word as two's complement and sign-extend it to accumulator width.
    function automatic acc_t widen(input logic [DATA_W-1:0] v);
        return acc_t'(pixel_t'(v));
    endfunction

endpackage

// File: rtl/conv_mac3x3.sv
// Combinational 9-tap signed multiply-accumulate; index r*3+c selects kernel/window tap (r,c).
module conv_mac3x3
    import conv_2d_pkg::*;
(
    input  logic [8:0][DATA_W-1:0] knl,
    input  logic [8:0][DATA_W-1:0] win,
    output logic [ACC_W-1:0]       sum
);

    acc_t acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            acc = acc + widen(knl[i]) * widen(win[i]);
        end
    end

    assign sum = acc;

endmodule

// File: rtl/conv_2d_3x3.sv
// Streaming 3x3 correlation: kernel and window column shift registers, registered Q1.7 output.
// Define CONV2D_SAT_EN to clamp the output to [MIN_Q, MAX_Q]; otherwise the result wraps.
module conv_2d_3x3
    import conv_2d_pkg::*;
(
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_load_knl,
    input  logic              i_en_conv,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [DATA_W-1:0] i_data3,
    output logic [DATA_W-1:0] o_pixel,
    output logic              o_valid
);

    logic [2:0][2:0][DATA_W-1:0] knl;
    logic [2:0][2:0][DATA_W-1:0] win;
    logic [1:0]                  col_cnt;
    logic                        valid_pend;
    logic [ACC_W-1:0]            mac_sum;
    acc_t                        shifted;
    logic [DATA_W-1:0]           pixel_next;

    conv_mac3x3 u_mac (
        .knl (knl),
        .win (win),
        .sum (mac_sum)
    );

    assign shifted = $signed(mac_sum) >>> FRAC_W;

    always_comb begin
        pixel_next = DATA_W'(shifted);
`ifdef CONV2D_SAT_EN
        if (shifted > acc_t'(MAX_Q)) begin
            pixel_next = MAX_Q;
        end else if (shifted < acc_t'(MIN_Q)) begin
            pixel_next = MIN_Q;
        end
`endif
    end

    // valid_pend marks that the window just filled, so its sum is registered on the next edge.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            knl        <= '0;
            win        <= '0;
            col_cnt    <= '0;
            valid_pend <= 1'b0;
            o_pixel    <= '0;
            o_valid    <= 1'b0;
        end else if (i_load_knl) begin
            for (int r = 0; r < 3; r++) begin
                knl[r][0] <= knl[r][1];
                knl[r][1] <= knl[r][2];
            end
            knl[0][2]  <= i_data1;
            knl[1][2]  <= i_data2;
            knl[2][2]  <= i_data3;
            col_cnt    <= '0;
            valid_pend <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            o_valid <= valid_pend;
            if (valid_pend) begin
                o_pixel <= pixel_next;
            end
            if (i_en_conv) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2]  <= i_data1;
                win[1][2]  <= i_data2;
                win[2][2]  <= i_data3;
                col_cnt    <= (col_cnt == 2'd3) ? 2'd3 : col_cnt + 2'd1;
                valid_pend <= (col_cnt >= 2'd2);
            end else begin
                valid_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_2d_3x3.sv
// Self-checking bench for conv_2d_3x3: constant vector table, randomized run against an
// arithmetic reference model, and hand sequences for mid-stream reset and load/enable overlap.
module tb_conv_2d_3x3;

    logic       clk;
    logic       i_rst;
    logic       i_load_knl;
    logic       i_en_conv;
    logic [7:0] i_data1;
    logic [7:0] i_data2;
    logic [7:0] i_data3;
    logic [7:0] o_pixel;
    logic       o_valid;

    conv_2d_3x3 dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_load_knl (i_load_knl),
        .i_en_conv  (i_en_conv),
        .i_data1    (i_data1),
        .i_data2    (i_data2),
        .i_data3    (i_data3),
        .o_pixel    (o_pixel),
        .o_valid    (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CONV2D_SAT_EN
    localparam logic [7:0] SAT_PIX = 8'h7F;
`else
    localparam logic [7:0] SAT_PIX = 8'h80;
`endif

    typedef struct {
        bit         rst;
        bit         load;
        bit         en;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] d3;
        logic [7:0] pix;
        bit         vld;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    // Reference model: kernel/window as integer matrices, results delivered one edge late.
    int         mk[3][3];
    int         mw[3][3];
    int         mcnt;
    bit         mpend;
    logic [7:0] mpend_pix;
    logic [7:0] mexp_pix;
    bit         mexp_vld;

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [7:0] ref_pixel();
        int s;
        int q;
        s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += mk[r][c] * mw[r][c];
        q = s >>> 7;
`ifdef CONV2D_SAT_EN
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
`endif
        return 8'(q & 255);
    endfunction

    task automatic applyStimulus(input bit rst, input bit load, input bit en,
                                 input logic [7:0] d1, input logic [7:0] d2,
                                 input logic [7:0] d3);
        i_rst      = rst;
        i_load_knl = load;
        i_en_conv  = en;
        i_data1    = d1;
        i_data2    = d2;
        i_data3    = d3;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    mk[r][c] = 0;
                    mw[r][c] = 0;
                end
            mcnt     = 0;
            mpend    = 0;
            mexp_pix = 8'h00;
            mexp_vld = 0;
        end else if (load) begin
            for (int r = 0; r < 3; r++) begin
                mk[r][0] = mk[r][1];
                mk[r][1] = mk[r][2];
            end
            mk[0][2] = sx(d1);
            mk[1][2] = sx(d2);
            mk[2][2] = sx(d3);
            mcnt     = 0;
            mpend    = 0;
            mexp_vld = 0;
        end else begin
            mexp_vld = mpend;
            if (mpend) mexp_pix = mpend_pix;
            if (en) begin
                for (int r = 0; r < 3; r++) begin
                    mw[r][0] = mw[r][1];
                    mw[r][1] = mw[r][2];
                end
                mw[0][2] = sx(d1);
                mw[1][2] = sx(d2);
                mw[2][2] = sx(d3);
                if (mcnt < 3) mcnt++;
                mpend = (mcnt == 3);
                if (mpend) mpend_pix = ref_pixel();
            end else begin
                mpend = 0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_pix, input bit exp_vld);
        checks++;
        if (o_pixel !== exp_pix || o_valid !== exp_vld) begin
            errors++;
            $display("[TB] FAIL %s: got pixel=%h valid=%b, expected pixel=%h valid=%b",
                     name, o_pixel, o_valid, exp_pix, exp_vld);
        end
    endtask

    task automatic addVec(input bit rst, input bit load, input bit en,
                          input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                          input logic [7:0] pix, input bit vld);
        vecs.push_back('{rst, load, en, d1, d2, d3, pix, vld});
    endtask

    initial begin
        i_rst = 1'b1; i_load_knl = 1'b0; i_en_conv = 1'b0;
        i_data1 = '0; i_data2 = '0; i_data3 = '0;

        // Center-only -1.0 kernel over 0x20 pixels, then a 0x80 center pixel.
        addVec(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        addVec(0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        addVec(0, 1, 0, 8'h00, 8'h80, 8'h00, 8'h00, 0);
        addVec(0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        addVec(0, 0, 1, 8'h20, 8'h20, 8'h20, 8'h00, 0);
        addVec(0, 0, 1, 8'h20, 8'h20, 8'h20, 8'h00, 0);
        addVec(0, 0, 1, 8'h20, 8'h20, 8'h20, 8'h00, 0);
        addVec(0, 0, 1, 8'h20, 8'h20, 8'h20, 8'hE0, 1);
        addVec(0, 0, 1, 8'h20, 8'h80, 8'h20, 8'hE0, 1);
        addVec(0, 0, 1, 8'h20, 8'h20, 8'h20, 8'hE0, 1);
        addVec(0, 0, 0, 8'h00, 8'h00, 8'h00, SAT_PIX, 1);
        addVec(0, 0, 0, 8'h00, 8'h00, 8'h00, SAT_PIX, 0);
        // All taps 0.125 over 0.5 pixels.
        addVec(0, 1, 0, 8'h10, 8'h10, 8'h10, SAT_PIX, 0);
        addVec(0, 1, 0, 8'h10, 8'h10, 8'h10, SAT_PIX, 0);
        addVec(0, 1, 0, 8'h10, 8'h10, 8'h10, SAT_PIX, 0);
        addVec(0, 0, 1, 8'h40, 8'h40, 8'h40, SAT_PIX, 0);
        addVec(0, 0, 1, 8'h40, 8'h40, 8'h40, SAT_PIX, 0);
        addVec(0, 0, 1, 8'h40, 8'h40, 8'h40, SAT_PIX, 0);
        addVec(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h48, 1);
        // Column order: k1..k9 = 1..9, lone 0x7F at row 1 column 0 selects k4.
        addVec(0, 1, 0, 8'h01, 8'h04, 8'h07, 8'h48, 0);
        addVec(0, 1, 0, 8'h02, 8'h05, 8'h08, 8'h48, 0);
        addVec(0, 1, 0, 8'h03, 8'h06, 8'h09, 8'h48, 0);
        addVec(0, 0, 1, 8'h00, 8'h7F, 8'h00, 8'h48, 0);
        addVec(0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h48, 0);
        addVec(0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h48, 0);
        addVec(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h03, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].en,
                          vecs[i].d1, vecs[i].d2, vecs[i].d3);
            checkOutput($sformatf("vec%0d", i), vecs[i].pix, vecs[i].vld);
        end

        for (int round = 0; round < 4; round++) begin
            for (int j = 0; j < 3; j++) begin
                applyStimulus(0, 1, 0, 8'($urandom), 8'($urandom), 8'($urandom));
                checkOutput($sformatf("rand_load%0d_%0d", round, j), mexp_pix, mexp_vld);
            end
            for (int j = 0; j < 30; j++) begin
                applyStimulus(0, 0, ($urandom_range(0, 4) != 0),
                              8'($urandom), 8'($urandom), 8'($urandom));
                checkOutput($sformatf("rand%0d_%0d", round, j), mexp_pix, mexp_vld);
            end
        end

        // Mid-stream reset clears everything; the zeroed kernel then yields 0 outputs.
        applyStimulus(0, 0, 1, 8'h11, 8'h22, 8'h33);
        applyStimulus(1, 0, 1, 8'h44, 8'h55, 8'h66);
        checkOutput("rst_mid", 8'h00, 0);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(0, 0, 1, 8'($urandom), 8'($urandom), 8'($urandom));
            checkOutput($sformatf("rst_refill%0d", j), 8'h00, 0);
        end
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 8'h00);
        checkOutput("rst_zero_knl", 8'h00, 1);

        // Load and enable together: kernel shifts, pending result dropped, count restarts.
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00);
        applyStimulus(0, 1, 0, 8'h00, 8'h80, 8'h00);
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00);
        for (int j = 0; j < 3; j++) applyStimulus(0, 0, 1, 8'h20, 8'h20, 8'h20);
        checkOutput("both_pre", 8'h00, 0);
        applyStimulus(0, 1, 1, 8'h7F, 8'h7F, 8'h7F);
        checkOutput("both_edge", 8'h00, 0);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(0, 0, 1, 8'h20, 8'h20, 8'h20);
            checkOutput($sformatf("both_refill%0d", j), 8'h00, 0);
        end
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 8'h00);
        checkOutput("both_result", 8'h3F, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
